// File: rtl/iterative_shift_controller_pkg.sv
// Shared constants for the iterative shift unit: datapath sizing, opcodes and FSM state encodings.
package iterative_shift_controller_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/iterative_shift_controller_shift_step.sv
// One shared shift stage: moves a value left or right by 1 or 2 bits with opcode-dependent fill.
module shift_step
  import iterative_shift_controller_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic [1:0]       opcode,
  input  logic             by_two,
  output logic [WIDTH-1:0] shifted
);

  logic             fill;
  logic [WIDTH-1:0] left_one;
  logic [WIDTH-1:0] left_two;
  logic [WIDTH-1:0] right_one;
  logic [WIDTH-1:0] right_two;

  // The MSB never changes during SRA, so it is always the captured sign bit.
  assign fill      = (opcode == OP_SRA) ? value[WIDTH-1] : 1'b0;
  assign left_one  = {value[WIDTH-2:0], 1'b0};
  assign left_two  = {value[WIDTH-3:0], 2'b00};
  assign right_one = {fill, value[WIDTH-1:1]};
  assign right_two = {{2{fill}}, value[WIDTH-1:2]};

  always_comb begin
    shifted = by_two ? right_two : right_one;
    if (opcode == OP_SLL) begin
      shifted = by_two ? left_two : left_one;
    end
  end

endmodule

// File: rtl/iterative_shift_controller.sv
// Multi-cycle SLL/SRL/SRA unit: reuses one 1/2-bit shift stage per cycle instead of a barrel shifter.
//   state   | meaning
//   S_IDLE  | ready for a new request
//   S_SHIFT | stepping the working register, 2 bits per cycle (1 on the last odd step)
//   S_DONE  | result final, result_valid pulses for this cycle
module iterative_shift_controller
  import iterative_shift_controller_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         opcode,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               ready,
  output logic               busy,
  output logic               result_valid,
  output logic [WIDTH-1:0]   result,
  output logic               op_err
);

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   work_step;
  logic [SHAMT_W-1:0] remaining;
  logic [SHAMT_W-1:0] step_amt;
  logic [1:0]         op_q;
  logic               by_two;
  logic               accept;
  logic               last_step;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .value   (work),
    .opcode  (op_q),
    .by_two  (by_two),
    .shifted (work_step)
  );

  assign by_two   = (remaining > SHAMT_W'(1));
  assign step_amt = by_two ? SHAMT_W'(2) : SHAMT_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    last_step    = 1'b0;
    ready        = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = (shamt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (remaining <= SHAMT_W'(2)) begin
          last_step  = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy         = 1'b1;
        result_valid = 1'b1;
        state_next   = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // result and op_err are loaded on entry to DONE so they are valid alongside the pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      work      <= '0;
      remaining <= '0;
      op_q      <= OP_SLL;
      result    <= '0;
      op_err    <= 1'b0;
    end else if (accept) begin
      work      <= data_in;
      remaining <= shamt;
      op_q      <= opcode;
      op_err    <= 1'b0;
      if (shamt == '0) begin
        result <= data_in;
        op_err <= (opcode == OP_RSV);
      end
    end else if (state == S_SHIFT) begin
      work      <= work_step;
      remaining <= remaining - step_amt;
      if (last_step) begin
        result <= work_step;
        op_err <= (op_q == OP_RSV);
      end
    end
  end

endmodule

// File: tb/tb_iterative_shift_controller.sv
// Self-checking bench for iterative_shift_controller: arithmetic reference model plus directed cases.
module tb_iterative_shift_controller;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  opcode;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        ready;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;
  logic        op_err;

  int n_checks = 0;
  int n_fail   = 0;

  iterative_shift_controller #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .opcode       (opcode),
    .data_in      (data_in),
    .shamt        (shamt),
    .ready        (ready),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .op_err       (op_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: result from plain arithmetic, timing from ceil(shamt/2)+1.
  int          m_left;
  logic [31:0] m_pending;
  logic        m_pending_err;
  logic [31:0] m_held;
  logic        m_held_err;

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d, input int s);
    case (op)
      2'b00:   return d << s;
      2'b10:   return 32'($signed(d) >>> s);
      default: return d >> s;
    endcase
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_left     = 0;
      m_held     = 32'h0;
      m_held_err = 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
        m_pending     = ref_shift(opcode, data_in, int'(shamt));
        m_pending_err = (opcode == 2'b11);
        m_left        = (int'(shamt) + 1) / 2 + 1;
        m_held_err    = 1'b0;
      end
    end else begin
      if (m_left == 1) begin
        m_held     = m_pending;
        m_held_err = m_pending_err;
      end
      m_left--;
    end
  end

  logic model_on = 1'b0;

  always @(negedge clock) begin
    if (model_on && !reset) begin
      check("m_ready", 32'(ready), 32'(m_left == 0));
      check("m_busy", 32'(busy), 32'(m_left > 0));
      check("m_valid", 32'(result_valid), 32'(m_left == 1));
      check("m_result", result, (m_left == 1) ? m_pending : m_held);
      check("m_op_err", 32'(op_err), 32'((m_left == 1) ? m_pending_err : m_held_err));
    end
  end

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!result_valid && n < 40);
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] d,
                        input logic [4:0] s, input logic [31:0] exp_res, input int exp_lat,
                        input logic exp_err);
    int n;
    @(negedge clock);
    start = 1'b1; opcode = op; data_in = d; shamt = s;
    @(posedge clock);
    #1;
    start   = 1'b0;
    data_in = $urandom;
    shamt   = 5'($urandom);
    opcode  = 2'($urandom);
    wait_valid(n);
    check({name, "_lat"}, 32'(n), 32'(exp_lat));
    check({name, "_res"}, result, exp_res);
    check({name, "_err"}, 32'(op_err), 32'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; opcode = 2'b00; data_in = 32'h0; shamt = 5'd0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_ready", 32'(ready), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_valid", 32'(result_valid), 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_op_err", 32'(op_err), 32'h0);
    model_on = 1'b1;

    run_op("srl4", 2'b01, 32'hF000_0000, 5'd4, 32'h0F00_0000, 3, 1'b0);

    // Reset in cycle 3 of a 20-bit SLL aborts it and clears the held result.
    @(negedge clock);
    start = 1'b1; opcode = 2'b00; data_in = 32'h0000_0001; shamt = 5'd20;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (2) @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("midrst_result", result, 32'h0);
    check("midrst_valid", 32'(result_valid), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("postrst_ready", 32'(ready), 32'h1);
    run_op("srl31", 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 17, 1'b0);

    run_op("sra31", 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 17, 1'b0);
    run_op("sra3", 2'b10, 32'h4000_0000, 5'd3, 32'h0800_0000, 3, 1'b0);
    run_op("sll5", 2'b00, 32'h0000_0001, 5'd5, 32'h0000_0020, 4, 1'b0);
    run_op("sll0", 2'b00, 32'h1234_5678, 5'd0, 32'h1234_5678, 1, 1'b0);
    run_op("sra_pos", 2'b10, 32'h7654_3210, 5'd8, 32'h0076_5432, 5, 1'b0);

    // start held high through SHIFT and DONE: second request waits for ready.
    @(negedge clock);
    start = 1'b1; opcode = 2'b00; data_in = 32'h0000_0003; shamt = 5'd10;
    @(posedge clock);
    #1;
    opcode = 2'b01; data_in = 32'hFFFF_FFFF; shamt = 5'd1;
    wait_valid(n);
    check("held1_lat", 32'(n), 32'd6);
    check("held1_res", result, 32'h0000_0C00);
    wait_valid(n);
    start = 1'b0;
    check("held2_lat", 32'(n), 32'd3);
    check("held2_res", result, 32'h7FFF_FFFF);

    run_op("rsv", 2'b11, 32'h0000_0100, 5'd8, 32'h0000_0001, 5, 1'b1);
    @(negedge clock);
    check("rsv_hold_err", 32'(op_err), 32'h1);
    run_op("after_rsv", 2'b00, 32'h0000_0001, 5'd1, 32'h0000_0002, 2, 1'b0);

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iterative_shift_controller.md
Name: iterative_shift_controller

Overview:
- Multi-cycle shift unit for the ALU; executes SLL, SRL and SRA by any amount from 0 to 31.
- Repeatedly applies one shared 1-bit/2-bit shift stage to a working register, replacing a full 32-bit barrel shifter.
- The ALU issue logic drives it with a start/ready handshake and receives a one-cycle result_valid pulse.

Parameters:
- WIDTH, 32, datapath width in bits; must be 32 for this release.
- SHAMT_W, 5, shift-amount width; equals log2(WIDTH).

Ports:
- clock  input  1  rising-edge system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only when ready=1
- opcode  input  2  00=SLL, 01=SRL, 10=SRA, 11=reserved
- data_in  input  32  operand to shift
- shamt  input  5  shift amount, 0..31
- ready  output  1  high in IDLE only
- busy  output  1  high in SHIFT and DONE
- result_valid  output  1  one-cycle pulse when result is final
- result  output  32  shifted value; held stable until the next accepted start
- op_err  output  1  high with result_valid when the accepted opcode was 11

Behaviour:
- Reset (async, active-high):
  - state=IDLE; working reg, remaining count, result, result_valid and op_err all 0.
  - ready=1 and busy=0 once reset deasserts.
- States:
  - IDLE: ready=1.
    - On start=1 at a clock edge, capture data_in, opcode and shamt.
    - Go to DONE if shamt==0, else go to SHIFT.
  - SHIFT: each cycle apply one step to the working reg.
    - remaining>=2: shift by 2, remaining -= 2.
    - remaining==1: shift by 1, remaining = 0.
    - Go to DONE when the post-step remaining==0.
  - DONE: result <= working reg; result_valid=1 for exactly this cycle; return to IDLE next cycle.
- Latency:
  - Accepted start at edge T gives ceil(shamt/2) SHIFT cycles, then DONE.
  - result_valid is high in cycle ceil(shamt/2)+1 after T.
  - shamt=0 takes 1 cycle; shamt=31 takes 17 cycles.
  - Back-to-back throughput: one new start per (latency+1) cycles.
- Shift semantics:
  - SLL fills with zeros at the LSBs.
  - SRL fills with zeros at the MSBs.
  - SRA fills with the captured bit 31, which stays constant for the whole operation: 2 copies on a 2-bit step, 1 copy on a 1-bit step.
- Reserved opcode 11 executes as SRL and sets op_err=1 alongside result_valid.
- op_err clears on the next accepted start.
- Boundary conditions:
  - start while busy is ignored; captured operands are unaffected.
  - Input changes after capture have no effect.
  - Reset asserted mid-operation aborts immediately: no result_valid pulse, result cleared to 0.
  - start in the cycle DONE is active is ignored, because ready is still 0 in that cycle.
- Outputs are registered or decoded from state only; no combinational path from inputs to outputs.

Decomposition:
- Shared Verilog include shift_ctrl_defs.vh holds:
  - opcode constants OP_SLL, OP_SRL, OP_SRA, OP_RSV;
  - state encodings S_IDLE, S_SHIFT, S_DONE (2-bit binary).
- One combinational sub-module, shift_step:
  - Inputs: 32-bit value, opcode, a 1-bit "by two" select.
  - Output: value shifted by 1 or 2 according to opcode, fill bits as above.
  - Built from the team's fixed-distance shift stages plus fill muxing; instantiated once and reused every SHIFT cycle.

Test Plan:
- Reset mid-operation: start SLL shamt=20, assert reset in cycle 3 -> result=0, no result_valid, ready=1 after reset release; a following SRL 0x80000000 by 31 gives 0x00000001 at cycle 17.
- SRL: data_in=0xF0000000, shamt=4 -> result_valid in cycle 3 after start, result=0x0F000000, op_err=0.
- SRA: data_in=0x80000000, shamt=31 -> valid in cycle 17, result=0xFFFFFFFF. Also data_in=0x40000000, shamt=3 -> 0x08000000 in cycle 3.
- SLL odd amount and zero amount: data_in=0x00000001, shamt=5 -> 0x00000020 in cycle 4. Then shamt=0 with data_in=0x12345678 -> 0x12345678 in cycle 1.
- start held high during busy: second operand 0xFFFFFFFF presented while SHIFT is active -> ignored; first result correct; the second request is accepted only once ready=1.
- Reserved opcode: opcode=11, data_in=0x00000100, shamt=8 -> result=0x00000001, op_err=1 with result_valid; the next accepted start clears op_err.
